// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================
// pc_pkg : shared PC width, fetch constants and state encoding
// Rev 1.0
// ============================================================
package pc_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;
  localparam logic [PC_W-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_incr.sv
`default_nettype none
// ============================================================
// pc_incr : combinational next-sequential-instruction adder
// Rev 1.0
// ============================================================
module pc_incr
  import pc_pkg::*;
(
  input  logic [PC_W-1:0] i_pc,
  output logic [PC_W-1:0] o_pc_plus4
);

  localparam logic [PC_W-1:0] C_STEP = INSTR_BYTES;

  // Carry out of the top bit is dropped so the PC wraps modulo 2^32.
  assign o_pc_plus4 = i_pc + C_STEP;

endmodule
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================
// pc_fetch : program counter and instruction-fetch sequencer
// Rev 1.0
// ============================================================
module pc_fetch
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            imem_ready,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  output logic            fetch_valid,
  output logic [PC_W-1:0] fetch_pc,
  output logic [PC_W-1:0] fetch_pc_plus4
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_pc_plus4;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] r_pend_pc;
  logic            r_pend_valid;
  logic            r_fetch_valid;
  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_fetch_pc_plus4;
  logic [PC_W-1:0] w_fetch_pc_next;
  logic [PC_W-1:0] w_fetch_pc_plus4_next;
  logic            w_req;
  logic            w_redirect;
  logic            w_complete;
  logic            w_deliver;

  assign w_redirect = jump | branch_taken;
  assign w_target   = word_align(jump ? jump_target : branch_target);
  assign w_complete = w_req & imem_ready;
  // A completing fetch is on the wrong path if any redirect is live or buffered.
  assign w_deliver  = w_complete & ~w_redirect & ~r_pend_valid;

  pc_incr u_incr_pc (
    .i_pc       (r_pc),
    .o_pc_plus4 (w_pc_plus4)
  );

  assign w_fetch_pc_next = w_deliver ? r_pc : r_fetch_pc;

  pc_incr u_incr_fetch (
    .i_pc       (w_fetch_pc_next),
    .o_pc_plus4 (w_fetch_pc_plus4_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = stall ? HOLD : FETCH;
      FETCH:   if (w_complete) w_state_next = stall ? HOLD : FETCH;
      HOLD:    if (!stall) w_state_next = FETCH;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_req = 1'b0;
    case (r_state)
      FETCH:   w_req = 1'b1;
      default: w_req = 1'b0;
    endcase
  end

  always_comb begin
    w_pc_next = r_pc;
    if (r_state == FETCH) begin
      if (w_complete) begin
        if (w_redirect) begin
          w_pc_next = w_target;
        end else if (r_pend_valid) begin
          w_pc_next = r_pend_pc;
        end else begin
          w_pc_next = w_pc_plus4;
        end
      end
    end else if (w_redirect) begin
      w_pc_next = w_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc             <= RESET_PC;
      r_pend_pc        <= '0;
      r_pend_valid     <= 1'b0;
      r_fetch_valid    <= 1'b0;
      r_fetch_pc       <= '0;
      r_fetch_pc_plus4 <= '0;
    end else begin
      r_pc          <= w_pc_next;
      r_fetch_valid <= w_deliver;
      if (w_deliver) begin
        r_fetch_pc       <= w_fetch_pc_next;
        r_fetch_pc_plus4 <= w_fetch_pc_plus4_next;
      end
      // Address must stay stable until the handshake, so redirects are parked here.
      if (w_complete) begin
        r_pend_valid <= 1'b0;
      end else if (w_req && w_redirect) begin
        r_pend_pc    <= w_target;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign imem_req       = w_req;
  assign imem_addr      = r_pc;
  assign fetch_valid    = r_fetch_valid;
  assign fetch_pc       = r_fetch_pc;
  assign fetch_pc_plus4 = r_fetch_pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ============================================================
// tb_pc_fetch : vector table, corner sequences and random run
// Rev 1.0
// ============================================================
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        imem_ready = 1'b0;

  logic        imem_req, w_imem_req;
  logic [31:0] imem_addr, w_imem_addr;
  logic        fetch_valid, w_fetch_valid;
  logic [31:0] fetch_pc, w_fetch_pc;
  logic [31:0] fetch_pc_plus4, w_fetch_pc_plus4;

  int n_cmp = 0;
  int n_bad = 0;

  pc_fetch dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .imem_ready(imem_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .fetch_pc_plus4(fetch_pc_plus4)
  );

  pc_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .imem_ready(imem_ready),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .fetch_valid(w_fetch_valid),
    .fetch_pc(w_fetch_pc), .fetch_pc_plus4(w_fetch_pc_plus4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        s, r, b;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_fv;
    logic [31:0] e_fpc, e_fpc4;
  } row_t;

  localparam int NROWS = 22;
  row_t tbl [NROWS];

  function automatic row_t mk(input logic s, input logic r, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt, input logic er,
                              input logic [31:0] ea, input logic ev, input logic [31:0] ep,
                              input logic [31:0] ep4);
    row_t x;
    x.s = s; x.r = r; x.b = b; x.bt = bt; x.j = j; x.jt = jt;
    x.e_req = er; x.e_addr = ea; x.e_fv = ev; x.e_fpc = ep; x.e_fpc4 = ep4;
    return x;
  endfunction

  // Reference model: a request is either outstanding or not; IDLE and HOLD look alike.
  logic        m_req, m_fv, m_pend_has;
  logic [31:0] m_pc, m_fpc, m_fpc4, m_pend;

  task automatic model_reset(input logic [31:0] rpc);
    m_req = 1'b0; m_fv = 1'b0; m_pend_has = 1'b0;
    m_pc = rpc; m_fpc = '0; m_fpc4 = '0; m_pend = '0;
  endtask

  task automatic model_edge();
    logic [31:0] t;
    logic        redir;
    redir = jump || branch_taken;
    t = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
    m_fv = 1'b0;
    if (m_req) begin
      if (imem_ready) begin
        if (redir) m_pc = t;
        else if (m_pend_has) m_pc = m_pend;
        else begin
          m_fv = 1'b1; m_fpc = m_pc; m_fpc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
        end
        m_pend_has = 1'b0;
        m_req = !stall;
      end else if (redir) begin
        m_pend = t; m_pend_has = 1'b1;
      end
    end else begin
      if (redir) m_pc = t;
      m_req = !stall;
    end
  endtask

  task automatic clear_inputs();
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0; imem_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   32'h0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0,   32'h4);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4,   32'h8);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8,   32'hC);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC,   32'h10);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'hC,   32'h10);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'hC,   32'h10);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'hC,   32'h10);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h10,  32'h14);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'h14,  32'h18);
    tbl[11] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h1C,  1'b1, 32'h18,  32'h1C);
    tbl[12] = mk(1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 32'h0,   1'b1, 32'h20,  1'b1, 32'h1C,  32'h20);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h20,  1'b0, 32'h1C,  32'h20);
    tbl[14] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h20,  1'b0, 32'h1C,  32'h20);
    tbl[15] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h1C,  32'h20);
    tbl[16] = mk(1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h200, 1'b1, 32'h104, 1'b1, 32'h100, 32'h104);
    tbl[17] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h100, 32'h104);
    tbl[18] = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200, 32'h204);
    tbl[19] = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h401, 1'b0, 32'h208, 1'b1, 32'h204, 32'h208);
    tbl[20] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h400, 1'b0, 32'h204, 32'h208);
    tbl[21] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h400, 1'b0, 32'h204, 32'h208);

    // Directed vector table from reset.
    do_reset();
    for (int i = 0; i < NROWS; i++) begin
      stall = tbl[i].s; imem_ready = tbl[i].r;
      branch_taken = tbl[i].b; branch_target = tbl[i].bt;
      jump = tbl[i].j; jump_target = tbl[i].jt;
      #1;
      check($sformatf("row%0d imem_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      check($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].e_addr);
      check($sformatf("row%0d fetch_valid", i), {31'b0, fetch_valid}, {31'b0, tbl[i].e_fv});
      check($sformatf("row%0d fetch_pc", i), fetch_pc, tbl[i].e_fpc);
      check($sformatf("row%0d fetch_pc_plus4", i), fetch_pc_plus4, tbl[i].e_fpc4);
      @(negedge clk);
    end

    // Address wrap from a high reset PC.
    do_reset();
    imem_ready = 1'b1;
    #1;
    check("wrap reset addr", w_imem_addr, 32'hFFFF_FFF8);
    check("wrap reset req", {31'b0, w_imem_req}, 32'd0);
    @(negedge clk); #1;
    check("wrap addr0", w_imem_addr, 32'hFFFF_FFF8);
    @(negedge clk); #1;
    check("wrap addr1", w_imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check("wrap addr2", w_imem_addr, 32'h0000_0000);
    check("wrap fetch_pc", w_fetch_pc, 32'hFFFF_FFFC);
    check("wrap fetch_pc_plus4", w_fetch_pc_plus4, 32'h0000_0000);

    // Stall with an outstanding request, then asynchronous reset mid-fetch.
    do_reset();
    imem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    imem_ready = 1'b0; stall = 1'b1;
    #1;
    check("stall req held", {31'b0, imem_req}, 32'd1);
    check("stall addr", imem_addr, 32'h4);
    @(negedge clk); #1;
    check("stall req held2", {31'b0, imem_req}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst req", {31'b0, imem_req}, 32'd0);
    check("async rst addr", imem_addr, 32'h0);
    check("async rst fv", {31'b0, fetch_valid}, 32'd0);
    check("async rst fpc", fetch_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    #1;
    check("restart idle req", {31'b0, imem_req}, 32'd0);
    check("restart idle fv", {31'b0, fetch_valid}, 32'd0);
    @(negedge clk); #1;
    check("restart req", {31'b0, imem_req}, 32'd1);
    check("restart addr", imem_addr, 32'h0);
    check("restart no spurious fv", {31'b0, fetch_valid}, 32'd0);
    @(negedge clk); #1;
    check("restart first fv", {31'b0, fetch_valid}, 32'd1);
    check("restart first fpc", fetch_pc, 32'h0);

    // Random stimulus against the reference model.
    do_reset();
    model_reset(32'h0);
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 9) < 7);
      jump = ($urandom_range(0, 99) < 8);
      branch_taken = ($urandom_range(0, 99) < 12);
      jump_target = $urandom;
      branch_target = $urandom;
      #1;
      check($sformatf("rand%0d imem_req", c), {31'b0, imem_req}, {31'b0, m_req});
      check($sformatf("rand%0d imem_addr", c), imem_addr, m_pc);
      check($sformatf("rand%0d fetch_valid", c), {31'b0, fetch_valid}, {31'b0, m_fv});
      check($sformatf("rand%0d fetch_pc", c), fetch_pc, m_fpc);
      check($sformatf("rand%0d fetch_pc_plus4", c), fetch_pc_plus4, m_fpc4);
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
